// File: rtl/uart_transmitter_if.sv
// Byte-in / serial-out handshake bundle for uart_transmitter.
// The master produces bytes and the slave (the transmitter) reports line and frame status.
interface uart_transmitter_if;
   logic       tx_start;
   logic [7:0] tx_in;
   logic       tx_out;
   logic       tx_busy;
   logic       tx_done;

   modport master (output tx_start, output tx_in,
                   input  tx_out, input  tx_busy, input  tx_done);
   modport slave  (input  tx_start, input  tx_in,
                   output tx_out, output tx_busy, output tx_done);
endinterface

// File: rtl/uart_transmitter.sv
// UART transmit serializer: start bit, 8 data bits LSB first, optional parity bit, stop bit.
// All outputs are registered, and the line idles high.
module uart_transmitter #(
   parameter int unsigned CLKS_PER_BIT = 16,
   parameter int unsigned PARITY       = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   uart_transmitter_if.slave tx_if
);
   localparam int unsigned     CNT_W   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_START  = 3'd1;
   localparam logic [2:0] S_DATA   = 3'd2;
   localparam logic [2:0] S_PARITY = 3'd3;
   localparam logic [2:0] S_STOP   = 3'd4;

   logic [2:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       idx_q, idx_d;
   logic [7:0]       shreg_q, shreg_d;
   logic             tx_out_q, tx_out_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             bit_end;
   logic             par_bit;

   assign bit_end = (cnt_q == CNT_MAX);
   assign par_bit = (^shreg_q) ^ (PARITY == 2);

   // tx_out_d holds the level of the bit about to begin, so the line is a flop output.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      idx_d    = idx_q;
      shreg_d  = shreg_q;
      tx_out_d = tx_out_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      if (state_q != S_IDLE) begin
         cnt_d = bit_end ? '0 : cnt_q + CNT_W'(1);
      end
      case (state_q)
         S_IDLE: begin
            tx_out_d = 1'b1;
            busy_d   = 1'b0;
            if (tx_if.tx_start) begin
               shreg_d  = tx_if.tx_in;
               state_d  = S_START;
               tx_out_d = 1'b0;
               busy_d   = 1'b1;
               cnt_d    = '0;
            end
         end
         S_START: begin
            if (bit_end) begin
               state_d  = S_DATA;
               idx_d    = '0;
               tx_out_d = shreg_q[0];
            end
         end
         S_DATA: begin
            if (bit_end) begin
               if (idx_q == 3'd7) begin
                  if (PARITY != 0) begin
                     state_d  = S_PARITY;
                     tx_out_d = par_bit;
                  end else begin
                     state_d  = S_STOP;
                     tx_out_d = 1'b1;
                  end
               end else begin
                  idx_d    = idx_q + 3'd1;
                  tx_out_d = shreg_q[idx_q + 3'd1];
               end
            end
         end
         S_PARITY: begin
            if (bit_end) begin
               state_d  = S_STOP;
               tx_out_d = 1'b1;
            end
         end
         S_STOP: begin
            if (bit_end) begin
               state_d  = S_IDLE;
               tx_out_d = 1'b1;
               busy_d   = 1'b0;
               done_d   = 1'b1;
            end
         end
         default: begin
            state_d  = S_IDLE;
            tx_out_d = 1'b1;
            busy_d   = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         idx_q    <= '0;
         shreg_q  <= '0;
         tx_out_q <= 1'b1;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         idx_q    <= idx_d;
         shreg_q  <= shreg_d;
         tx_out_q <= tx_out_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   assign tx_if.tx_out  = tx_out_q;
   assign tx_if.tx_busy = busy_q;
   assign tx_if.tx_done = done_q;
endmodule

// File: tb/tb_uart_transmitter.sv
// Directed bench for uart_transmitter: four instances cover no/even/odd parity at 4 clk/bit and 1 clk/bit.
// Frames are listed LSB-first as {stop, [parity], data, start}, with hand-computed parity.
module tb_uart_transmitter;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic       start[4];
   logic [7:0] din[4];
   logic       out_w[4];
   logic       busy_w[4];
   logic       done_w[4];

   uart_transmitter_if if0 ();
   uart_transmitter_if if1 ();
   uart_transmitter_if if2 ();
   uart_transmitter_if if3 ();

   uart_transmitter #(.CLKS_PER_BIT(4), .PARITY(0)) u0 (.clk(clk), .rst_n(rst_n), .tx_if(if0));
   uart_transmitter #(.CLKS_PER_BIT(4), .PARITY(1)) u1 (.clk(clk), .rst_n(rst_n), .tx_if(if1));
   uart_transmitter #(.CLKS_PER_BIT(4), .PARITY(2)) u2 (.clk(clk), .rst_n(rst_n), .tx_if(if2));
   uart_transmitter #(.CLKS_PER_BIT(1), .PARITY(0)) u3 (.clk(clk), .rst_n(rst_n), .tx_if(if3));

   assign if0.tx_start = start[0];
   assign if1.tx_start = start[1];
   assign if2.tx_start = start[2];
   assign if3.tx_start = start[3];
   assign if0.tx_in = din[0];
   assign if1.tx_in = din[1];
   assign if2.tx_in = din[2];
   assign if3.tx_in = din[3];
   assign out_w[0] = if0.tx_out;
   assign out_w[1] = if1.tx_out;
   assign out_w[2] = if2.tx_out;
   assign out_w[3] = if3.tx_out;
   assign busy_w[0] = if0.tx_busy;
   assign busy_w[1] = if1.tx_busy;
   assign busy_w[2] = if2.tx_busy;
   assign busy_w[3] = if3.tx_busy;
   assign done_w[0] = if0.tx_done;
   assign done_w[1] = if1.tx_done;
   assign done_w[2] = if2.tx_done;
   assign done_w[3] = if3.tx_done;

   int unsigned checks = 0;
   int unsigned failures = 0;

   typedef struct {
      int unsigned k;
      logic [7:0]  data;
      logic [10:0] frame;
      int unsigned nbits;
      int          inject;
   } vec_t;

   vec_t vecs[11];

   function automatic int unsigned cpb(input int unsigned k);
      return (k == 3) ? 1 : 4;
   endfunction

   task automatic chk(input string name, input int unsigned k, input int c,
                      input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s inst=%0d cycle=%0d got=%0h expected=%0h", name, k, c, act, exp);
      end
   endtask

   task automatic chk_idle_all(input string name);
      for (int unsigned k = 0; k < 4; k++) begin
         chk({name, "_out"},  k, -1, 32'(out_w[k]),  32'd1);
         chk({name, "_busy"}, k, -1, 32'(busy_w[k]), 32'd0);
         chk({name, "_done"}, k, -1, 32'(done_w[k]), 32'd0);
      end
   endtask

   // Entered and left 1 time unit after a rising edge; inject >= 0 raises tx_start with 0xFF mid-frame.
   task automatic run_frame(input int unsigned k, input logic [7:0] data,
                            input logic [10:0] frame, input int unsigned nbits, input int inject);
      int unsigned c_per;
      c_per = cpb(k);
      din[k]   = data;
      start[k] = 1'b1;
      @(posedge clk); #1;
      start[k] = 1'b0;
      din[k]   = ~data;
      for (int c = 0; c < int'(nbits * c_per); c++) begin
         if (c == inject) begin
            start[k] = 1'b1;
            din[k]   = 8'hFF;
         end else begin
            start[k] = 1'b0;
         end
         chk("frame_out",  k, c, 32'(out_w[k]),  32'(frame[c / int'(c_per)]));
         chk("frame_busy", k, c, 32'(busy_w[k]), 32'd1);
         chk("frame_done", k, c, 32'(done_w[k]), 32'd0);
         @(posedge clk); #1;
      end
      start[k] = 1'b0;
      chk("end_done", k, -1, 32'(done_w[k]), 32'd1);
      chk("end_busy", k, -1, 32'(busy_w[k]), 32'd0);
      chk("end_out",  k, -1, 32'(out_w[k]),  32'd1);
      @(posedge clk); #1;
      chk("post_done", k, -1, 32'(done_w[k]), 32'd0);
      chk("post_busy", k, -1, 32'(busy_w[k]), 32'd0);
      chk("post_out",  k, -1, 32'(out_w[k]),  32'd1);
   endtask

   initial begin
      logic [10:0] f55;
      logic [10:0] faa;
      logic        exp_out;
      logic        exp_busy;
      logic        exp_done;

      vecs[0]  = '{0, 8'hA5, {1'b0, 1'b1, 8'hA5, 1'b0}, 10, -1};
      vecs[1]  = '{0, 8'h00, {1'b0, 1'b1, 8'h00, 1'b0}, 10, -1};
      vecs[2]  = '{0, 8'hFF, {1'b0, 1'b1, 8'hFF, 1'b0}, 10, -1};
      vecs[3]  = '{1, 8'h07, {1'b1, 1'b1, 8'h07, 1'b0}, 11, -1};
      vecs[4]  = '{1, 8'hFF, {1'b1, 1'b0, 8'hFF, 1'b0}, 11, -1};
      vecs[5]  = '{1, 8'h80, {1'b1, 1'b1, 8'h80, 1'b0}, 11, -1};
      vecs[6]  = '{2, 8'h07, {1'b1, 1'b0, 8'h07, 1'b0}, 11, -1};
      vecs[7]  = '{2, 8'h00, {1'b1, 1'b1, 8'h00, 1'b0}, 11, -1};
      vecs[8]  = '{3, 8'hA5, {1'b0, 1'b1, 8'hA5, 1'b0}, 10, -1};
      vecs[9]  = '{0, 8'h3C, {1'b0, 1'b1, 8'h3C, 1'b0}, 10, 13};
      vecs[10] = '{3, 8'h3C, {1'b0, 1'b1, 8'h3C, 1'b0}, 10, 9};

      for (int unsigned k = 0; k < 4; k++) begin
         start[k] = 1'b0;
         din[k]   = 8'h00;
      end

      // Reset held while tx_start toggles.
      for (int i = 0; i < 6; i++) begin
         for (int unsigned k = 0; k < 4; k++) begin
            start[k] = i[0];
            din[k]   = 8'h5A;
         end
         @(posedge clk); #1;
         chk_idle_all("rst_hold");
      end
      for (int unsigned k = 0; k < 4; k++) start[k] = 1'b0;
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         chk_idle_all("rst_release");
      end

      foreach (vecs[i]) begin
         run_frame(vecs[i].k, vecs[i].data, vecs[i].frame, vecs[i].nbits, vecs[i].inject);
      end

      // Back-to-back with tx_start held: the tx_done cycle is the one IDLE cycle between frames.
      f55 = {1'b0, 1'b1, 8'h55, 1'b0};
      faa = {1'b0, 1'b1, 8'hAA, 1'b0};
      din[0]   = 8'h55;
      start[0] = 1'b1;
      @(posedge clk); #1;
      din[0] = 8'hAA;
      for (int c = 0; c < 86; c++) begin
         if (c == 41) start[0] = 1'b0;
         if (c < 40) begin
            exp_out = f55[c / 4]; exp_busy = 1'b1; exp_done = 1'b0;
         end else if (c == 40) begin
            exp_out = 1'b1; exp_busy = 1'b0; exp_done = 1'b1;
         end else if (c < 81) begin
            exp_out = faa[(c - 41) / 4]; exp_busy = 1'b1; exp_done = 1'b0;
         end else begin
            exp_out = 1'b1; exp_busy = 1'b0; exp_done = (c == 81);
         end
         chk("b2b_out",  0, c, 32'(out_w[0]),  32'(exp_out));
         chk("b2b_busy", 0, c, 32'(busy_w[0]), 32'(exp_busy));
         chk("b2b_done", 0, c, 32'(done_w[0]), 32'(exp_done));
         @(posedge clk); #1;
      end

      // Asynchronous reset during data bit 3 of 0x00.
      din[0]   = 8'h00;
      start[0] = 1'b1;
      @(posedge clk); #1;
      start[0] = 1'b0;
      for (int c = 0; c < 17; c++) begin
         @(posedge clk); #1;
      end
      chk("pre_rst_out",  0, 17, 32'(out_w[0]),  32'd0);
      chk("pre_rst_busy", 0, 17, 32'(busy_w[0]), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_rst_out",  0, -1, 32'(out_w[0]),  32'd1);
      chk("async_rst_busy", 0, -1, 32'(busy_w[0]), 32'd0);
      chk("async_rst_done", 0, -1, 32'(done_w[0]), 32'd0);
      for (int i = 0; i < 2; i++) begin
         @(posedge clk); #1;
         chk_idle_all("rst_mid");
      end
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk_idle_all("rst_mid_release");
      run_frame(0, 8'h00, {1'b0, 1'b1, 8'h00, 1'b0}, 10, -1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
